// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command words and arbiter state encoding
package sdram_pkg;
    localparam int CMD_W = 18;
    // {cs_n, ras_n, cas_n, we_n, ba[1:0], addr[11:0]}
    localparam logic [CMD_W-1:0] CMD_NOP = 18'h1c000;
    localparam logic [CMD_W-1:0] CMD_PRE = 18'h08400;
    localparam logic [CMD_W-1:0] CMD_REF = 18'h04000;
    localparam logic [CMD_W-1:0] CMD_MRS = 18'h00032;
    localparam logic [CMD_W-1:0] CMD_ACT = 18'h0c000;
    localparam logic [CMD_W-1:0] CMD_WR  = 18'h10000;
    localparam logic [CMD_W-1:0] CMD_RD  = 18'h14000;
    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } arb_state_t;
endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit: fixed-priority command arbiter and pin register for the SDRAM controller
module sdram_arbit #(
    parameter int CMD_W = 18,
    parameter logic [CMD_W-1:0] NOP_CMD = 18'h1c000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] ini_cmd,
    input  logic             ini_end,
    input  logic             ref_req,
    input  logic [CMD_W-1:0] ref_cmd,
    input  logic             ref_end,
    output logic             ref_en,
    input  logic             wr_req,
    input  logic [CMD_W-1:0] wr_cmd,
    input  logic             wr_end,
    output logic             wr_en,
    input  logic             rd_req,
    input  logic [CMD_W-1:0] rd_cmd,
    input  logic             rd_end,
    output logic             rd_en,
    output logic             sdram_cs_n,
    output logic             sdram_ras_n,
    output logic             sdram_cas_n,
    output logic             sdram_we_n,
    output logic [1:0]       sdram_ba,
    output logic [11:0]      sdram_addr,
    output logic             sdram_cke
);
    import sdram_pkg::*;

    arb_state_t       state, state_nxt;
    logic [CMD_W-1:0] cmd_sel, cmd_q;
    logic             cke_q;

    // state register; reset always returns ownership to the init engine
    always_ff @(posedge clk) begin
        state <= rst ? ST_INIT : state_nxt;
    end

    // next state and command select; every grant closes back through ARBIT
    always_comb begin
        state_nxt = state;
        cmd_sel   = NOP_CMD;
        case (state)
            ST_INIT: begin
                cmd_sel   = ini_cmd;
                state_nxt = ini_end ? ST_ARBIT : ST_INIT;
            end
            ST_ARBIT: begin
                state_nxt = ref_req ? ST_AREF :
                            wr_req  ? ST_WRITE :
                            rd_req  ? ST_READ : ST_ARBIT;
            end
            ST_AREF: begin
                cmd_sel   = ref_cmd;
                state_nxt = ref_end ? ST_ARBIT : ST_AREF;
            end
            ST_WRITE: begin
                cmd_sel   = wr_cmd;
                state_nxt = wr_end ? ST_ARBIT : ST_WRITE;
            end
            ST_READ: begin
                cmd_sel   = rd_cmd;
                state_nxt = rd_end ? ST_ARBIT : ST_READ;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // pin register; reset overrides the selected command with NOP and drops cke
    always_ff @(posedge clk) begin
        cmd_q <= rst ? NOP_CMD : cmd_sel;
        cke_q <= !rst;
    end

    assign ref_en = state == ST_AREF;
    assign wr_en  = state == ST_WRITE;
    assign rd_en  = state == ST_READ;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr} = cmd_q;
    assign sdram_cke = cke_q;
endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter and sequencer for the SDRAM controller. It sits between the per-function engines (init, auto-refresh, write, read) and the SDRAM command pins. It holds the pins on the init engine until initialisation completes, then grants exclusive bus ownership to one engine at a time, with fixed priority refresh > write > read. It muxes the granted engine's 18-bit command word onto the registered pin outputs.

## Interface
Parameters:
- CMD_W, 18, command word width; format {cs_n, ras_n, cas_n, we_n, ba[1:0], addr[11:0]}
- NOP_CMD, 18'h1c000, idle command driven whenever no engine owns the bus

Ports:
- clk  in  1  controller clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- ini_cmd  in  18  init engine command
- ini_end  in  1  init complete; sampled only in INIT
- ref_req  in  1  refresh request, level, held until granted
- ref_cmd  in  18  refresh engine command
- ref_end  in  1  one-cycle pulse, refresh sequence done
- ref_en  out  1  refresh grant
- wr_req / wr_cmd / wr_end / wr_en: same roles for the write engine
- rd_req / rd_cmd / rd_end / rd_en: same roles for the read engine
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_ba  out  2  bank address pins
- sdram_addr  out  12  address pins
- sdram_cke  out  1  clock enable; 0 in reset, 1 otherwise

## Operation
- FSM states: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- INIT: selected command = ini_cmd. When ini_end=1, go to ARBIT. ini_end is ignored in all other states.
- ARBIT: selected command = NOP_CMD. Evaluate requests each cycle:
  - ref_req → AREF
  - else wr_req → WRITE
  - else rd_req → READ
  - else stay in ARBIT.
- AREF / WRITE / READ: the matching grant (ref_en / wr_en / rd_en) = 1 for the whole state. Selected command = that engine's cmd. Return to ARBIT on that engine's *_end pulse.
- *_end pulses from non-granted engines are ignored.
- No preemption. Write and read engines must close their burst when they see ref_req. The arbiter never aborts a grant.
- Requests seen in the same cycle as *_end are not granted directly. The FSM always passes through ARBIT, so there is at least one NOP cycle between grants.
- Grants are one-hot. At most one of ref_en, wr_en, rd_en is high at any time.

## Timing
- Grants are registered decodes of the state, so they rise on the edge that enters the state.
- Pin outputs are registered: pins at cycle n+1 = selected command at cycle n.
- Request to grant: req high in ARBIT at edge k → *_en high after edge k. That engine's first non-NOP command reaches the pins after edge k+2.
- *_end at edge k → *_en low and state ARBIT after edge k. Pins show NOP from edge k+1.
- Reset values: ref_en = wr_en = rd_en = 0; pins = NOP_CMD (cs_n=0, ras_n=cas_n=we_n=1, ba=0, addr=0); sdram_cke=0.
- rst asserted mid-grant: on the next edge all grants drop, state becomes INIT and pins show NOP. There is no completion handshake.
- While rst=1, the pins are forced to NOP_CMD regardless of ini_cmd.

## Structure
- Shared package sdram_pkg holds:
  - command constants CMD_NOP, CMD_PRE, CMD_REF, CMD_MRS, CMD_ACT, CMD_WR, CMD_RD;
  - the CMD_W constant;
  - the arbiter state encoding, which the engines' testbenches reuse for monitors.
- Single flat module. No sub-module is warranted; the mux and FSM are too small to split.

## Test plan
- Reset then init: ini_cmd toggles PRE/REF/MRS, ini_end pulses at cycle 200 → pins track ini_cmd with 1-cycle latency; all grants stay 0 until ARBIT; pins = 18'h1c000 from cycle 202.
- Refresh alone: ref_req at cycle 1000, ref_end pulse 11 cycles after ref_en → ref_en high for exactly 11 cycles; REF word 18'h04000 appears on the pins exactly once; NOP afterwards.
- Simultaneous ref_req, wr_req, rd_req in ARBIT → order of grants is ref, then write, then read, each separated by at least one NOP cycle; never two grants high at once.
- wr_end and ref_req in the same cycle during WRITE → one ARBIT cycle, then ref_en; wr_en does not re-assert while ref_req is held.
- Stray rd_end during AREF → ignored; state stays AREF until ref_end.
- rst pulsed 3 cycles into READ → on the next edge rd_en=0, pins = NOP, cke=0, state INIT; no grant until a new ini_end.
